// File: rtl/regfile_pkg.sv
// -----------------------------------------------------------------------------
// regfile_pkg
// Shared definitions for the parametrised register bank: default geometry and
// the clear-sequencer state type.
// -----------------------------------------------------------------------------
package regfile_pkg;

    localparam int REGFILE_WIDTH_DEF = 32'd16;
    localparam int REGFILE_DEPTH_DEF = 32'd16;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } regfile_state_t;

endpackage : regfile_pkg

// File: rtl/regfile_clear_seq.sv
// -----------------------------------------------------------------------------
// regfile_clear_seq
// IDLE/CLEAR sequencer that walks an index over every register, one entry per
// clock, so the bank can zero itself in hardware.
// Ports:
//   clk      in   clock, rising edge
//   reset    in   asynchronous active-low reset
//   clr_req  in   start-clear request, sampled only in IDLE
//   busy     out  high while the clear sequence runs
//   clr_we   out  clear write strobe for the bank
//   clr_idx  out  entry being cleared this cycle
// -----------------------------------------------------------------------------
module regfile_clear_seq
    import regfile_pkg::*;
#(
    parameter  int DEPTH  = REGFILE_DEPTH_DEF,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clr_req,
    output logic              busy,
    output logic              clr_we,
    output logic [ADDR_W-1:0] clr_idx
);

    regfile_state_t    state_q, state_d;
    logic [ADDR_W-1:0] idx_q, idx_d;

    // Next-state and index logic of the clear sequencer.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        case (state_q)
            IDLE: begin
                if (clr_req) begin
                    state_d = CLEAR;
                end else begin
                    state_d = IDLE;
                end
                idx_d = {ADDR_W{1'b0}};
            end
            CLEAR: begin
                // The last entry returns the index to 0 so the next run starts clean.
                if (idx_q == ADDR_W'(DEPTH - 1)) begin
                    state_d = IDLE;
                    idx_d   = {ADDR_W{1'b0}};
                end else begin
                    state_d = CLEAR;
                    idx_d   = idx_q + {{(ADDR_W-1){1'b0}}, 1'b1};
                end
            end
            default: begin
                state_d = IDLE;
                idx_d   = {ADDR_W{1'b0}};
            end
        endcase
    end

    // State and index registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            idx_q   <= {ADDR_W{1'b0}};
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    assign busy    = (state_q == CLEAR);
    assign clr_we  = (state_q == CLEAR);
    assign clr_idx = idx_q;

endmodule : regfile_clear_seq

// File: rtl/regfile_bank.sv
// -----------------------------------------------------------------------------
// regfile_bank
// Parametrised register file: one write port, two combinational read ports,
// optional hard-wired-zero r0 and a hardware clear sequencer.
// Optional feature macro: REGFILE_BYPASS_EN -- when defined, a write that will
// commit on the coming edge is forwarded to a read port addressing the same
// entry in the same cycle.
// Ports:
//   clk, reset             clock and asynchronous active-low reset
//   wr_en/wr_addr/wr_data  write port (ALU result bus)
//   rd_addr_a/rd_data_a    read port A (combinational)
//   rd_addr_b/rd_data_b    read port B (combinational)
//   clr_req                start-clear request
//   busy                   clear sequence in progress
// -----------------------------------------------------------------------------
module regfile_bank
    import regfile_pkg::*;
#(
    parameter  int WIDTH   = REGFILE_WIDTH_DEF,
    parameter  int DEPTH   = REGFILE_DEPTH_DEF,
    parameter  int ZERO_R0 = 0,
    localparam int ADDR_W  = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WIDTH-1:0]  wr_data,
    input  logic [ADDR_W-1:0] rd_addr_a,
    output logic [WIDTH-1:0]  rd_data_a,
    input  logic [ADDR_W-1:0] rd_addr_b,
    output logic [WIDTH-1:0]  rd_data_b,
    input  logic              clr_req,
    output logic              busy
);

    logic [WIDTH-1:0]  mem_q [DEPTH];
    logic [WIDTH-1:0]  mem_d [DEPTH];
    logic              clr_we_s;
    logic [ADDR_W-1:0] clr_idx_s;
    logic              in_range_s;
    logic              r0_hit_s;
    logic              wr_ok_s;
    logic [WIDTH-1:0]  rd_a_s;
    logic [WIDTH-1:0]  rd_b_s;

    regfile_clear_seq #(
        .DEPTH (DEPTH)
    ) u_clear_seq (
        .clk     (clk),
        .reset   (reset),
        .clr_req (clr_req),
        .busy    (busy),
        .clr_we  (clr_we_s),
        .clr_idx (clr_idx_s)
    );

    // Extra MSB so the comparison also works when DEPTH is a power of two.
    assign in_range_s = ({1'b0, wr_addr} < (ADDR_W+1)'(DEPTH));
    assign r0_hit_s   = (ZERO_R0 != 0) && (wr_addr == {ADDR_W{1'b0}});
    // A write commits only in IDLE, in range, and not to a hard-wired r0.
    assign wr_ok_s    = wr_en && !busy && in_range_s && !r0_hit_s;

    // Next contents: clear writes take priority over (and block) normal writes.
    always_comb begin
        mem_d = mem_q;
        for (int i = 0; i < DEPTH; i++) begin
            if (clr_we_s && (clr_idx_s == ADDR_W'(i))) begin
                mem_d[i] = {WIDTH{1'b0}};
            end else if (wr_ok_s && (wr_addr == ADDR_W'(i))) begin
                mem_d[i] = wr_data;
            end else begin
                mem_d[i] = mem_q[i];
            end
        end
    end

    // Storage array.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= {WIDTH{1'b0}};
            end
        end else begin
            mem_q <= mem_d;
        end
    end

    // Stored-content read muxes; unmatched (out-of-range) addresses fall through to 0.
    always_comb begin
        rd_a_s = {WIDTH{1'b0}};
        rd_b_s = {WIDTH{1'b0}};
        for (int i = 0; i < DEPTH; i++) begin
            rd_a_s = (rd_addr_a == ADDR_W'(i)) ? mem_q[i] : rd_a_s;
            rd_b_s = (rd_addr_b == ADDR_W'(i)) ? mem_q[i] : rd_b_s;
        end
        if ((ZERO_R0 != 0) && (rd_addr_a == {ADDR_W{1'b0}})) begin
            rd_a_s = {WIDTH{1'b0}};
        end else begin
            rd_a_s = rd_a_s;
        end
        if ((ZERO_R0 != 0) && (rd_addr_b == {ADDR_W{1'b0}})) begin
            rd_b_s = {WIDTH{1'b0}};
        end else begin
            rd_b_s = rd_b_s;
        end
    end

`ifdef REGFILE_BYPASS_EN
    // Forward a committing write; gated by reset so reads stay 0 while held in reset.
    always_comb begin
        if (reset && wr_ok_s && (rd_addr_a == wr_addr)) begin
            rd_data_a = wr_data;
        end else begin
            rd_data_a = rd_a_s;
        end
        if (reset && wr_ok_s && (rd_addr_b == wr_addr)) begin
            rd_data_b = wr_data;
        end else begin
            rd_data_b = rd_b_s;
        end
    end
`else
    assign rd_data_a = rd_a_s;
    assign rd_data_b = rd_b_s;
`endif

endmodule : regfile_bank

// File: tb/tb_regfile_bank.sv
// -----------------------------------------------------------------------------
// tb_regfile_bank
// Two instances share one stimulus stream: a default 16x16 bank and a 12-deep
// bank with hard-wired-zero r0. A behavioural model per instance predicts the
// outputs; directed steps pin the model with literal expectations, then a
// randomized phase exercises writes, clears and resets together.
// -----------------------------------------------------------------------------
module tb_regfile_bank;

    logic        clk = 1'b0;
    logic        reset;
    logic        wr_en;
    logic        clr_req;
    logic [3:0]  wr_addr;
    logic [3:0]  ra;
    logic [3:0]  rb;
    logic [15:0] wr_data;
    logic [15:0] rda0, rdb0, rda1, rdb1;
    logic        busy0, busy1;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    regfile_bank u_dut0 (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_addr_a(ra), .rd_data_a(rda0), .rd_addr_b(rb), .rd_data_b(rdb0),
        .clr_req(clr_req), .busy(busy0)
    );

    regfile_bank #(.WIDTH(16), .DEPTH(12), .ZERO_R0(1)) u_dut1 (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_addr_a(ra), .rd_data_a(rda1), .rd_addr_b(rb), .rd_data_b(rdb1),
        .clr_req(clr_req), .busy(busy1)
    );

    // ---------------- behavioural model ----------------
    // Each bank is an array of values plus the position of an ongoing clear
    // (-1 when no clear is running).
    logic [15:0] mem_m [2][16];
    int          depth_m [2] = '{16, 12};
    bit          zr_m    [2] = '{1'b0, 1'b1};
    int          cpos    [2] = '{-1, -1};

    function automatic bit wr_ok(input int k);
        return reset && (cpos[k] < 0) && wr_en && (int'(wr_addr) < depth_m[k])
               && !(zr_m[k] && wr_addr == 4'd0);
    endfunction

    function automatic logic [15:0] exp_rd(input int k, input logic [3:0] a);
        if (!reset) return 16'h0000;
        if (int'(a) >= depth_m[k]) return 16'h0000;
        if (zr_m[k] && a == 4'd0) return 16'h0000;
`ifdef REGFILE_BYPASS_EN
        if (wr_ok(k) && a == wr_addr) return wr_data;
`endif
        return mem_m[k][a];
    endfunction

    function automatic logic exp_busy(input int k);
        return reset && (cpos[k] >= 0);
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < 2; k++) begin
                cpos[k] <= -1;
                for (int i = 0; i < 16; i++) mem_m[k][i] <= 16'h0000;
            end
        end else begin
            for (int k = 0; k < 2; k++) begin
                if (cpos[k] >= 0) begin
                    mem_m[k][cpos[k]] <= 16'h0000;
                    cpos[k] <= (cpos[k] + 1 == depth_m[k]) ? -1 : cpos[k] + 1;
                end else begin
                    if (wr_ok(k)) mem_m[k][wr_addr] <= wr_data;
                    if (clr_req) cpos[k] <= 0;
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Compare process: every mid-cycle, both banks against the model.
    always @(negedge clk) begin
        check("busy0", {31'd0, busy0}, {31'd0, exp_busy(0)});
        check("busy1", {31'd0, busy1}, {31'd0, exp_busy(1)});
        check("rda0", {16'd0, rda0}, {16'd0, exp_rd(0, ra)});
        check("rdb0", {16'd0, rdb0}, {16'd0, exp_rd(0, rb)});
        check("rda1", {16'd0, rda1}, {16'd0, exp_rd(1, ra)});
        check("rdb1", {16'd0, rdb1}, {16'd0, exp_rd(1, rb)});
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [3:0] a, input logic [15:0] d);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic peek(input logic [3:0] a, input logic [3:0] b);
        ra = a; rb = b;
        #1;
    endtask

    int b0, b1;

    initial begin
        reset = 1'b0; wr_en = 1'b0; clr_req = 1'b0;
        wr_addr = 4'd0; wr_data = 16'h0000; ra = 4'd0; rb = 4'd0;
        #2;
        check("rst_busy0", {31'd0, busy0}, 32'd0);
        peek(4'd3, 4'd15);
        check("rst_rda0", {16'd0, rda0}, 32'h0);
        check("rst_rdb0", {16'd0, rdb0}, 32'h0);
        tick(); tick();
        reset = 1'b1;

        // Basic writes and reads.
        wr(4'd3, 16'hA5A5);
        wr(4'd15, 16'h1234);
        peek(4'd3, 4'd15);
        check("rd3_a0", {16'd0, rda0}, 32'hA5A5);
        check("rd15_b0", {16'd0, rdb0}, 32'h1234);
        check("rd15_b1_oor", {16'd0, rdb1}, 32'h0);
        peek(4'd4, 4'd4);
        check("rd4_a0", {16'd0, rda0}, 32'h0);

        // r0 write: discarded on the ZERO_R0 bank, stored on the other.
        wr_en = 1'b1; wr_addr = 4'd0; wr_data = 16'hFFFF;
        peek(4'd0, 4'd0);
        check("r0_byp_a1", {16'd0, rda1}, 32'h0);
        tick();
        wr_en = 1'b0;
        peek(4'd0, 4'd0);
        check("r0_a1", {16'd0, rda1}, 32'h0);
        check("r0_b1", {16'd0, rdb1}, 32'h0);
        check("r0_a0", {16'd0, rda0}, 32'hFFFF);
        wr(4'd1, 16'h0101);
        peek(4'd1, 4'd1);
        check("r1_a1", {16'd0, rda1}, 32'h0101);

        // Same-cycle read of the address being written.
        wr_en = 1'b1; wr_addr = 4'd5; wr_data = 16'hBEEF;
        peek(4'd5, 4'd5);
`ifdef REGFILE_BYPASS_EN
        check("byp_pre_a0", {16'd0, rda0}, 32'hBEEF);
`else
        check("byp_pre_a0", {16'd0, rda0}, 32'h0);
`endif
        tick();
        wr_en = 1'b0;
        #1;
        check("byp_post_a0", {16'd0, rda0}, 32'hBEEF);

        // Out-of-range write on the 12-deep bank.
        wr(4'd13, 16'h1313);
        peek(4'd13, 4'd13);
        check("oor_a1", {16'd0, rda1}, 32'h0);
        check("oor_a0", {16'd0, rda0}, 32'h1313);

        // Fill, then clear with a mid-clear probe and an ignored write.
        for (int i = 0; i < 16; i++) wr(4'(i), 16'hC000 | 16'(i));
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        b0 = 0; b1 = 0;
        for (int c = 0; c < 40; c++) begin
            if (busy0) b0++;
            if (busy1) b1++;
            if (c == 5) begin
                peek(4'd4, 4'd10);
                check("mid_a0", {16'd0, rda0}, 32'h0);
                check("mid_b0", {16'd0, rdb0}, 32'hC00A);
                check("mid_a1", {16'd0, rda1}, 32'h0);
                check("mid_b1", {16'd0, rdb1}, 32'hC00A);
            end
            if (c == 8) begin
                wr_en = 1'b1; wr_addr = 4'd2; wr_data = 16'h7777;
            end
            if (c == 9) wr_en = 1'b0;
            tick();
        end
        check("busy_len0", b0, 32'd16);
        check("busy_len1", b1, 32'd12);
        for (int a = 0; a < 16; a++) begin
            peek(4'(a), 4'(a));
            check("post_clr0", {16'd0, rda0}, 32'h0);
            check("post_clr1", {16'd0, rda1}, 32'h0);
        end

        // Reset in the middle of a clear.
        for (int i = 0; i < 16; i++) wr(4'(i), 16'h5A00 | 16'(i));
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        repeat (7) tick();
        reset = 1'b0;
        peek(4'd10, 4'd3);
        check("rstclr_busy0", {31'd0, busy0}, 32'd0);
        check("rstclr_busy1", {31'd0, busy1}, 32'd0);
        check("rstclr_a0", {16'd0, rda0}, 32'h0);
        check("rstclr_b0", {16'd0, rdb0}, 32'h0);
        check("rstclr_a1", {16'd0, rda1}, 32'h0);
        tick();
        reset = 1'b1;
        wr(4'd6, 16'h0606);
        peek(4'd6, 4'd6);
        check("after_rst_a0", {16'd0, rda0}, 32'h0606);
        check("after_rst_b1", {16'd0, rdb1}, 32'h0606);

        // Back-to-back clears with clr_req held high.
        for (int i = 0; i < 16; i++) wr(4'(i), 16'(i + 1));
        clr_req = 1'b1;
        repeat (40) tick();
        clr_req = 1'b0;
        repeat (20) tick();

        // Randomized phase.
        repeat (3000) begin
            wr_en   = 1'($urandom_range(0, 1));
            wr_addr = 4'($urandom_range(0, 15));
            wr_data = 16'($urandom);
            ra      = 4'($urandom_range(0, 15));
            rb      = 4'($urandom_range(0, 15));
            clr_req = ($urandom_range(0, 31) == 0);
            reset   = ($urandom_range(0, 399) != 0);
            tick();
        end
        reset = 1'b1; wr_en = 1'b0; clr_req = 1'b0;
        repeat (20) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_regfile_bank
